phys_reg_read: RTL and testbench

- Register-read stage directly downstream of the issue stage (combined IQ/LSQ select).
- Accepts one issued entry per cycle and reads its source operands from the 64-entry physical register file. The file is owned here and written by two writeback ports.
- Applies same-cycle writeback bypass, selects immediate vs register for operand 2, and registers a decoded operand bundle for the execute/memory stages.
- Single pipeline register; 1-cycle latency.

---
 rtl/phys_reg_read_if.sv | 48 ++++
 rtl/phys_reg_read.sv | 185 ++++++++++++++++++
 tb/tb_phys_reg_read.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/phys_reg_read_if.sv
// Issue, writeback and execute-bundle signals of the register-read stage.
// The slave modport is the stage itself; the master modport drives it.
interface phys_reg_read_if #(
  parameter int IQLSQ_WIDTH = 137,
  parameter int PREG_BITS   = 6,
  parameter int DATA_WIDTH  = 32
);
  logic                   FREEZE;
  logic                   FLUSH_IN;
  logic                   ISS_valid_IN;
  logic                   ISS_mem_IN;
  logic [IQLSQ_WIDTH-1:0] ISS_data_IN;
  logic                   WB0_en_IN;
  logic [PREG_BITS-1:0]   WB0_reg_IN;
  logic [DATA_WIDTH-1:0]  WB0_data_IN;
  logic                   WB1_en_IN;
  logic [PREG_BITS-1:0]   WB1_reg_IN;
  logic [DATA_WIDTH-1:0]  WB1_data_IN;
  logic                   EXE_valid_OUT;
  logic                   EXE_mem_OUT;
  logic [DATA_WIDTH-1:0]  EXE_opA_OUT;
  logic [DATA_WIDTH-1:0]  EXE_opB_OUT;
  logic [DATA_WIDTH-1:0]  EXE_storeData_OUT;
  logic [5:0]             EXE_ctrl_OUT;
  logic [5:0]             EXE_aluCtrl_OUT;
  logic [PREG_BITS-1:0]   EXE_dest_OUT;
  logic                   EXE_needDest_OUT;
  logic [5:0]             EXE_rob_OUT;
  logic [31:0]            EXE_pc_OUT;
  logic [31:0]            EXE_instr_OUT;
  logic [31:0]            RR_issued_OUT;

  modport master (
    output FREEZE, FLUSH_IN, ISS_valid_IN, ISS_mem_IN, ISS_data_IN,
    output WB0_en_IN, WB0_reg_IN, WB0_data_IN, WB1_en_IN, WB1_reg_IN, WB1_data_IN,
    input  EXE_valid_OUT, EXE_mem_OUT, EXE_opA_OUT, EXE_opB_OUT, EXE_storeData_OUT,
    input  EXE_ctrl_OUT, EXE_aluCtrl_OUT, EXE_dest_OUT, EXE_needDest_OUT,
    input  EXE_rob_OUT, EXE_pc_OUT, EXE_instr_OUT, RR_issued_OUT
  );

  modport slave (
    input  FREEZE, FLUSH_IN, ISS_valid_IN, ISS_mem_IN, ISS_data_IN,
    input  WB0_en_IN, WB0_reg_IN, WB0_data_IN, WB1_en_IN, WB1_reg_IN, WB1_data_IN,
    output EXE_valid_OUT, EXE_mem_OUT, EXE_opA_OUT, EXE_opB_OUT, EXE_storeData_OUT,
    output EXE_ctrl_OUT, EXE_aluCtrl_OUT, EXE_dest_OUT, EXE_needDest_OUT,
    output EXE_rob_OUT, EXE_pc_OUT, EXE_instr_OUT, RR_issued_OUT
  );
endinterface

// File: rtl/phys_reg_read.sv
// Register-read stage: owns the physical register file, applies writeback
// bypass and registers one decoded operand bundle per cycle for execute/memory.
module phys_reg_read #(
  parameter int IQLSQ_WIDTH = 137,
  parameter int PREG_BITS   = 6,
  parameter int PHYS_REGS   = 64,
  parameter int DATA_WIDTH  = 32
) (
  input  logic          CLK,
  input  logic          RESET,
  phys_reg_read_if.slave rr
);

  typedef enum logic [1:0] {
    ACT_RESET,
    ACT_HOLD,
    ACT_SQUASH,
    ACT_LOAD
  } act_e;

  logic [DATA_WIDTH-1:0] r_regs [PHYS_REGS];

  logic                  r_valid;
  logic                  r_mem;
  logic [DATA_WIDTH-1:0] r_opA;
  logic [DATA_WIDTH-1:0] r_opB;
  logic [DATA_WIDTH-1:0] r_storeData;
  logic [5:0]            r_ctrl;
  logic [5:0]            r_aluCtrl;
  logic [PREG_BITS-1:0]  r_dest;
  logic                  r_needDest;
  logic [5:0]            r_rob;
  logic [31:0]           r_pc;
  logic [31:0]           r_instr;
  logic [31:0]           r_issued;
  logic                  r_pend_flush;

  logic [31:0]           w_pc;
  logic [5:0]            w_ctrl;
  logic                  w_immSrc;
  logic                  w_needDest;
  logic [PREG_BITS-1:0]  w_dest;
  logic [PREG_BITS-1:0]  w_src2;
  logic [PREG_BITS-1:0]  w_src1;
  logic [DATA_WIDTH-1:0] w_imm;
  logic [5:0]            w_aluCtrl;
  logic [5:0]            w_rob;
  logic [31:0]           w_instr;

  logic [DATA_WIDTH-1:0] w_src1_val;
  logic [DATA_WIDTH-1:0] w_src2_val;
  logic [DATA_WIDTH-1:0] w_opB;
  act_e                  w_act;

  assign w_pc       = rr.ISS_data_IN[136:105];
  assign w_ctrl     = rr.ISS_data_IN[103:98];
  assign w_immSrc   = rr.ISS_data_IN[97];
  assign w_needDest = rr.ISS_data_IN[96];
  assign w_dest     = rr.ISS_data_IN[95:90];
  assign w_src2     = rr.ISS_data_IN[88:83];
  assign w_src1     = rr.ISS_data_IN[81:76];
  assign w_imm      = rr.ISS_data_IN[75:44];
  assign w_aluCtrl  = rr.ISS_data_IN[43:38];
  assign w_rob      = rr.ISS_data_IN[37:32];
  assign w_instr    = rr.ISS_data_IN[31:0];

  // Register 0 reads as zero and is never bypassed; WB1 outranks WB0.
  function automatic logic [DATA_WIDTH-1:0] f_operand(
    input logic [PREG_BITS-1:0]  src,
    input logic [DATA_WIDTH-1:0] arr_val,
    input logic                  wb0_en,
    input logic [PREG_BITS-1:0]  wb0_reg,
    input logic [DATA_WIDTH-1:0] wb0_data,
    input logic                  wb1_en,
    input logic [PREG_BITS-1:0]  wb1_reg,
    input logic [DATA_WIDTH-1:0] wb1_data
  );
    logic [DATA_WIDTH-1:0] v;
    if (src == '0)
      v = '0;
    else if (wb1_en && (wb1_reg == src))
      v = wb1_data;
    else if (wb0_en && (wb0_reg == src))
      v = wb0_data;
    else
      v = arr_val;
    return v;
  endfunction

  always_comb begin
    w_src1_val = f_operand(w_src1, r_regs[w_src1],
                           rr.WB0_en_IN, rr.WB0_reg_IN, rr.WB0_data_IN,
                           rr.WB1_en_IN, rr.WB1_reg_IN, rr.WB1_data_IN);
    w_src2_val = f_operand(w_src2, r_regs[w_src2],
                           rr.WB0_en_IN, rr.WB0_reg_IN, rr.WB0_data_IN,
                           rr.WB1_en_IN, rr.WB1_reg_IN, rr.WB1_data_IN);
    w_opB      = w_immSrc ? w_imm : w_src2_val;
  end

  // Register file: writes ignore FREEZE/FLUSH; the later WB1 assignment wins a collision.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      for (int unsigned i = 0; i < PHYS_REGS; i++)
        r_regs[i] <= '0;
    end else begin
      if (rr.WB0_en_IN && (rr.WB0_reg_IN != '0))
        r_regs[rr.WB0_reg_IN] <= rr.WB0_data_IN;
      if (rr.WB1_en_IN && (rr.WB1_reg_IN != '0))
        r_regs[rr.WB1_reg_IN] <= rr.WB1_data_IN;
    end
  end

  always_comb begin
    w_act = ACT_LOAD;
    if (!RESET)
      w_act = ACT_RESET;
    else if (rr.FREEZE)
      w_act = ACT_HOLD;
    else if (rr.FLUSH_IN || r_pend_flush)
      w_act = ACT_SQUASH;
  end

  always_ff @(posedge CLK) begin
    case (w_act)
      ACT_RESET: begin
        r_valid      <= 1'b0;
        r_mem        <= 1'b0;
        r_opA        <= '0;
        r_opB        <= '0;
        r_storeData  <= '0;
        r_ctrl       <= '0;
        r_aluCtrl    <= '0;
        r_dest       <= '0;
        r_needDest   <= 1'b0;
        r_rob        <= '0;
        r_pc         <= '0;
        r_instr      <= '0;
        r_issued     <= '0;
        r_pend_flush <= 1'b0;
      end
      ACT_HOLD: begin
        if (rr.FLUSH_IN)
          r_pend_flush <= 1'b1;
      end
      ACT_SQUASH: begin
        r_valid      <= 1'b0;
        r_ctrl       <= '0;
        r_needDest   <= 1'b0;
        r_pend_flush <= 1'b0;
      end
      ACT_LOAD: begin
        r_valid     <= rr.ISS_valid_IN;
        r_mem       <= rr.ISS_mem_IN;
        r_opA       <= w_src1_val;
        r_opB       <= w_opB;
        r_storeData <= w_src2_val;
        r_aluCtrl   <= w_aluCtrl;
        r_dest      <= w_dest;
        r_rob       <= w_rob;
        r_pc        <= w_pc;
        r_instr     <= w_instr;
        r_ctrl      <= rr.ISS_valid_IN ? w_ctrl : '0;
        r_needDest  <= rr.ISS_valid_IN & w_needDest;
        if (rr.ISS_valid_IN)
          r_issued <= r_issued + 32'd1;
      end
      default: ;
    endcase
  end

  assign rr.EXE_valid_OUT     = r_valid;
  assign rr.EXE_mem_OUT       = r_mem;
  assign rr.EXE_opA_OUT       = r_opA;
  assign rr.EXE_opB_OUT       = r_opB;
  assign rr.EXE_storeData_OUT = r_storeData;
  assign rr.EXE_ctrl_OUT      = r_ctrl;
  assign rr.EXE_aluCtrl_OUT   = r_aluCtrl;
  assign rr.EXE_dest_OUT      = r_dest;
  assign rr.EXE_needDest_OUT  = r_needDest;
  assign rr.EXE_rob_OUT       = r_rob;
  assign rr.EXE_pc_OUT        = r_pc;
  assign rr.EXE_instr_OUT     = r_instr;
  assign rr.RR_issued_OUT     = r_issued;

endmodule

// File: tb/tb_phys_reg_read.sv
// Scoreboard bench for phys_reg_read: directed scenarios followed by random traffic.
module tb_phys_reg_read;

  logic CLK;
  logic RESET;

  phys_reg_read_if ifc ();

  phys_reg_read dut (
    .CLK   (CLK),
    .RESET (RESET),
    .rr    (ifc)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  typedef struct {
    logic [31:0] opA, opB, sd, pc, instr, cnt;
    logic [5:0]  ctrl, alu, dest, rob;
    logic        nd, mem;
  } bun_t;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  logic [31:0] mdl_mem [64];
  logic        mdl_pend;
  logic [31:0] mdl_cnt;
  logic        mdl_valid;
  bun_t        mdl_held;
  bun_t        sb_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_bundle(input string tag, input bun_t e);
    chk({tag, ".opA"},   ifc.EXE_opA_OUT,          e.opA);
    chk({tag, ".opB"},   ifc.EXE_opB_OUT,          e.opB);
    chk({tag, ".sd"},    ifc.EXE_storeData_OUT,    e.sd);
    chk({tag, ".ctrl"},  32'(ifc.EXE_ctrl_OUT),    32'(e.ctrl));
    chk({tag, ".alu"},   32'(ifc.EXE_aluCtrl_OUT), 32'(e.alu));
    chk({tag, ".dest"},  32'(ifc.EXE_dest_OUT),    32'(e.dest));
    chk({tag, ".nd"},    32'(ifc.EXE_needDest_OUT), 32'(e.nd));
    chk({tag, ".rob"},   32'(ifc.EXE_rob_OUT),     32'(e.rob));
    chk({tag, ".pc"},    ifc.EXE_pc_OUT,           e.pc);
    chk({tag, ".instr"}, ifc.EXE_instr_OUT,        e.instr);
    chk({tag, ".mem"},   32'(ifc.EXE_mem_OUT),     32'(e.mem));
  endtask

  function automatic logic [136:0] mk(
    input logic [31:0] pc, input logic [5:0] ctrl, input logic imm_src, input logic nd,
    input logic [5:0] dest, input logic [5:0] src2, input logic [5:0] src1,
    input logic [31:0] imm, input logic [5:0] alu, input logic [5:0] rob, input logic [31:0] instr);
    logic [2:0] rdy;
    rdy = 3'($urandom);
    return {pc, rdy[2], ctrl, imm_src, nd, dest, rdy[1], src2, rdy[0], src1, imm, alu, rob, instr};
  endfunction

  // Architectural value a source would see this cycle, including in-flight writebacks.
  function automatic logic [31:0] ref_read(input logic [5:0] r);
    if (r == 6'd0) return 32'd0;
    if (ifc.WB1_en_IN && ifc.WB1_reg_IN == r) return ifc.WB1_data_IN;
    if (ifc.WB0_en_IN && ifc.WB0_reg_IN == r) return ifc.WB0_data_IN;
    return mdl_mem[r];
  endfunction

  task automatic idle();
    ifc.FREEZE       = 1'b0;
    ifc.FLUSH_IN     = 1'b0;
    ifc.ISS_valid_IN = 1'b0;
    ifc.ISS_mem_IN   = 1'b0;
    ifc.ISS_data_IN  = '0;
    ifc.WB0_en_IN    = 1'b0;
    ifc.WB0_reg_IN   = '0;
    ifc.WB0_data_IN  = '0;
    ifc.WB1_en_IN    = 1'b0;
    ifc.WB1_reg_IN   = '0;
    ifc.WB1_data_IN  = '0;
  endtask

  task automatic wb0(input logic [5:0] r, input logic [31:0] d);
    ifc.WB0_en_IN = 1'b1; ifc.WB0_reg_IN = r; ifc.WB0_data_IN = d;
  endtask

  task automatic wb1(input logic [5:0] r, input logic [31:0] d);
    ifc.WB1_en_IN = 1'b1; ifc.WB1_reg_IN = r; ifc.WB1_data_IN = d;
  endtask

  task automatic issue(input logic m, input logic [136:0] e);
    ifc.ISS_valid_IN = 1'b1; ifc.ISS_mem_IN = m; ifc.ISS_data_IN = e;
  endtask

  // Called with inputs set (just after a negedge); advances one clock and
  // updates the reference model with what the stage should have done.
  task automatic step();
    bun_t nb;
    logic rst, frz, fl, v;
    logic [136:0] e;
    e        = ifc.ISS_data_IN;
    rst      = RESET;
    frz      = ifc.FREEZE;
    fl       = ifc.FLUSH_IN;
    v        = ifc.ISS_valid_IN;
    nb.opA   = ref_read(e[81:76]);
    nb.sd    = ref_read(e[88:83]);
    nb.opB   = e[97] ? e[75:44] : nb.sd;
    nb.pc    = e[136:105];
    nb.ctrl  = e[103:98];
    nb.nd    = e[96];
    nb.dest  = e[95:90];
    nb.alu   = e[43:38];
    nb.rob   = e[37:32];
    nb.instr = e[31:0];
    nb.mem   = ifc.ISS_mem_IN;
    nb.cnt   = 32'd0;
    @(posedge CLK);
    if (!rst) begin
      foreach (mdl_mem[i]) mdl_mem[i] = 32'd0;
      mdl_pend  = 1'b0;
      mdl_cnt   = 32'd0;
      mdl_valid = 1'b0;
      mdl_held  = '{default: '0};
    end else begin
      if (ifc.WB0_en_IN && ifc.WB0_reg_IN != 6'd0) mdl_mem[ifc.WB0_reg_IN] = ifc.WB0_data_IN;
      if (ifc.WB1_en_IN && ifc.WB1_reg_IN != 6'd0) mdl_mem[ifc.WB1_reg_IN] = ifc.WB1_data_IN;
      if (frz) begin
        mdl_pend = mdl_pend | fl;
      end else if (fl || mdl_pend) begin
        mdl_pend      = 1'b0;
        mdl_valid     = 1'b0;
        mdl_held.ctrl = '0;
        mdl_held.nd   = 1'b0;
      end else begin
        mdl_valid = v;
        mdl_held  = nb;
        if (v) begin
          mdl_cnt      = mdl_cnt + 32'd1;
          mdl_held.cnt = mdl_cnt;
          sb_q.push_back(mdl_held);
        end else begin
          mdl_held.ctrl = '0;
          mdl_held.nd   = 1'b0;
          mdl_held.cnt  = mdl_cnt;
        end
      end
    end
    #1;
    chk("valid",  32'(ifc.EXE_valid_OUT), 32'(mdl_valid));
    chk("issued", ifc.RR_issued_OUT, mdl_cnt);
    if (!rst) begin
      cmp_bundle("reset", mdl_held);
    end else if (frz) begin
      if (mdl_valid) begin
        cmp_bundle("hold", mdl_held);
      end else begin
        chk("hold.ctrl", 32'(ifc.EXE_ctrl_OUT), 32'(mdl_held.ctrl));
        chk("hold.nd",   32'(ifc.EXE_needDest_OUT), 32'(mdl_held.nd));
      end
    end
    @(negedge CLK);
  endtask

  // Monitor: every freshly loaded valid bundle must match the head of the scoreboard.
  initial begin : monitor
    logic r, f;
    bun_t e;
    forever begin
      @(posedge CLK);
      r = RESET;
      f = ifc.FREEZE;
      #1;
      if (r && !f) begin
        if (ifc.EXE_valid_OUT) begin
          if (sb_q.size() == 0) begin
            chk("sb.unexpected", 32'd1, 32'd0);
          end else begin
            e = sb_q.pop_front();
            cmp_bundle("sb", e);
            chk("sb.issued", ifc.RR_issued_OUT, e.cnt);
          end
        end else begin
          chk("bubble.ctrl", 32'(ifc.EXE_ctrl_OUT), 32'd0);
          chk("bubble.nd",   32'(ifc.EXE_needDest_OUT), 32'd0);
        end
      end
    end
  end

  initial begin : stim
    logic [5:0] s1, s2;
    RESET = 1'b0;
    idle();
    foreach (mdl_mem[i]) mdl_mem[i] = 32'd0;
    mdl_pend = 1'b0; mdl_cnt = 32'd0; mdl_valid = 1'b0; mdl_held = '{default: '0};
    @(negedge CLK);
    wb0(6'd9, 32'h9999_9999);
    step();
    idle();
    step();
    RESET = 1'b1;

    wb0(6'd5, 32'h0000_1234);
    step();
    idle(); step();
    issue(1'b0, mk(32'h100, 6'b000000, 1'b0, 1'b1, 6'd10, 6'd6, 6'd5, 32'h0, 6'd3, 6'd1, 32'hA1));
    step();
    chk("basic.opA", ifc.EXE_opA_OUT, 32'h0000_1234);
    chk("basic.opB", ifc.EXE_opB_OUT, 32'h0);
    chk("basic.rr",  ifc.RR_issued_OUT, 32'd1);

    idle();
    wb1(6'd7, 32'h0000_AAAA);
    wb0(6'd7, 32'h0000_5555);
    issue(1'b0, mk(32'h104, 6'b000000, 1'b0, 1'b1, 6'd11, 6'd0, 6'd7, 32'h0, 6'd4, 6'd2, 32'hA2));
    step();
    chk("bypass.opA", ifc.EXE_opA_OUT, 32'h0000_AAAA);
    idle();
    issue(1'b0, mk(32'h108, 6'b000000, 1'b0, 1'b0, 6'd0, 6'd7, 6'd7, 32'h0, 6'd4, 6'd3, 32'hA3));
    step();
    chk("collide.opA", ifc.EXE_opA_OUT, 32'h0000_AAAA);

    idle(); wb0(6'd9, 32'h0000_BEEF); step();
    idle();
    issue(1'b1, mk(32'h10C, 6'b000010, 1'b1, 1'b0, 6'd0, 6'd9, 6'd5, 32'hFFFF_FFFC, 6'd0, 6'd4, 32'hA4));
    step();
    chk("store.opB", ifc.EXE_opB_OUT, 32'hFFFF_FFFC);
    chk("store.sd",  ifc.EXE_storeData_OUT, 32'h0000_BEEF);
    chk("store.mem", 32'(ifc.EXE_mem_OUT), 32'd1);

    idle(); wb0(6'd0, 32'h0000_DEAD); step();
    idle(); wb0(6'd0, 32'h0000_DEAD); wb1(6'd0, 32'h0000_BEEF);
    issue(1'b0, mk(32'h110, 6'b000000, 1'b0, 1'b1, 6'd1, 6'd0, 6'd0, 32'h0, 6'd1, 6'd5, 32'hA5));
    step();
    chk("r0.opA", ifc.EXE_opA_OUT, 32'h0);

    idle();
    issue(1'b0, mk(32'h114, 6'b100001, 1'b0, 1'b1, 6'd12, 6'd2, 6'd5, 32'h0, 6'd2, 6'd6, 32'hA6));
    step();
    issue(1'b0, mk(32'h118, 6'b000001, 1'b0, 1'b1, 6'd13, 6'd3, 6'd3, 32'h0, 6'd2, 6'd7, 32'hA7));
    ifc.FREEZE = 1'b1; wb0(6'd3, 32'h0000_3333);
    step();
    ifc.FLUSH_IN = 1'b1; ifc.WB0_en_IN = 1'b0;
    step();
    ifc.FLUSH_IN = 1'b0;
    step();
    chk("freeze.valid", 32'(ifc.EXE_valid_OUT), 32'd1);
    ifc.FREEZE = 1'b0;
    step();
    chk("unfreeze.valid", 32'(ifc.EXE_valid_OUT), 32'd0);
    chk("unfreeze.ctrl",  32'(ifc.EXE_ctrl_OUT), 32'd0);
    chk("unfreeze.nd",    32'(ifc.EXE_needDest_OUT), 32'd0);
    idle();
    issue(1'b0, mk(32'h11C, 6'b000000, 1'b0, 1'b0, 6'd0, 6'd0, 6'd3, 32'h0, 6'd2, 6'd8, 32'hA8));
    step();
    chk("freeze.r3", ifc.EXE_opA_OUT, 32'h0000_3333);

    idle();
    issue(1'b0, mk(32'h120, 6'b000000, 1'b0, 1'b1, 6'd4, 6'd0, 6'd7, 32'h0, 6'd2, 6'd9, 32'hA9));
    RESET = 1'b0; wb0(6'd4, 32'h0000_4444);
    step();
    RESET = 1'b1;
    chk("reset.rr", ifc.RR_issued_OUT, 32'd0);
    idle();
    issue(1'b0, mk(32'h124, 6'b000000, 1'b0, 1'b0, 6'd0, 6'd7, 6'd4, 32'h0, 6'd2, 6'd10, 32'hAA));
    step();
    chk("reset.r4", ifc.EXE_opA_OUT, 32'h0);
    chk("reset.r7", ifc.EXE_storeData_OUT, 32'h0);

    for (int i = 0; i < 600; i++) begin
      idle();
      RESET      = ($urandom_range(0, 59) != 0);
      ifc.FREEZE   = ($urandom_range(0, 7) == 0);
      ifc.FLUSH_IN = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 1) == 1) wb0(6'($urandom_range(0, 7)), $urandom);
      if ($urandom_range(0, 2) == 0) wb1(6'($urandom_range(0, 7)), $urandom);
      if ($urandom_range(0, 9) < 7) begin
        s1 = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'($urandom_range(0, 7));
        s2 = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'($urandom_range(0, 7));
        issue(1'($urandom), mk($urandom, 6'($urandom), 1'($urandom), 1'($urandom), 6'($urandom),
                               s2, s1, $urandom, 6'($urandom), 6'($urandom), $urandom));
      end
      step();
    end

    RESET = 1'b1;
    idle();
    step();
    step();
    chk("sb.drained", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
